// File: rtl/qtree_match_pkg.sv
// Shared types and helpers for the quadtree range-match stage.
// Entry layout (MSB first): {valid, l, r, result}.
package qtree_match_pkg;

    localparam int unsigned STAT_WIDTH = 32;
    localparam int unsigned PENC_MAX   = 64;
    localparam int unsigned PENC_IDX_W = 6;

    typedef struct packed {
        logic [PENC_IDX_W-1:0] idx;
        logic                  any;
        logic                  multi;
    } penc_t;

    function automatic int unsigned entry_width(input int unsigned key_w, input int unsigned res_w);
        return 1 + 2 * key_w + res_w;
    endfunction

    // Priority encoder over up to PENC_MAX hit bits; idx is 0 when nothing hits.
    function automatic penc_t prio_encode(input logic [PENC_MAX-1:0] mask, input logic highest);
        penc_t       res;
        int unsigned cnt;
        res = '0;
        cnt = 0;
        for (int i = 0; i < PENC_MAX; i++) begin
            if (mask[i]) begin
                cnt = cnt + 1;
                if (highest || cnt == 1) res.idx = PENC_IDX_W'(i);
            end
        end
        res.any   = (cnt != 0);
        res.multi = (cnt > 1);
        return res;
    endfunction

endpackage

// File: rtl/qtree_match_cell.sv
// One range cell: row RAM with registered read (S0) and registered comparator (S1).
module qtree_match_cell
    import qtree_match_pkg::*;
#(
    parameter int unsigned KEY_WIDTH      = 16,
    parameter int unsigned RESULT_WIDTH   = 16,
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    localparam int unsigned ENTRY_W       = entry_width(KEY_WIDTH, RESULT_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      adv_i,
    input  logic                      wr_en_i,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [ENTRY_W-1:0]        wr_entry_i,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [KEY_WIDTH-1:0]      key_i,
    output logic                      hit_o,
    output logic [RESULT_WIDTH-1:0]   result_o
);

    localparam int unsigned DEPTH = 2 ** RAM_ADDR_WIDTH;

    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [ENTRY_W-1:0]      rd_q;
    logic                    e_valid;
    logic [KEY_WIDTH-1:0]    e_l;
    logic [KEY_WIDTH-1:0]    e_r;
    logic [RESULT_WIDTH-1:0] e_res;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_entry_i;
    end

    // Read register holds during a stall so later writes cannot disturb the in-flight lookup.
    always_ff @(posedge clk_i) begin
        if (adv_i) rd_q <= mem[rd_addr_i];
    end

    assign {e_valid, e_l, e_r, e_res} = rd_q;

    // An inverted range (l > r) can never satisfy both bounds.
    always_ff @(posedge clk_i) begin
        if (adv_i) begin
            hit_o    <= e_valid && (e_l <= key_i) && (key_i <= e_r);
            result_o <= e_res;
        end
    end

endmodule

// File: rtl/qtree_range_match.sv
// Range-match stage: row read, per-cell compare, priority select, with backpressure.
// Optional statistics counters are built when QTREE_MATCH_STATS_EN is defined.
module qtree_range_match
    import qtree_match_pkg::*;
#(
    parameter int unsigned KEY_WIDTH        = 16,
    parameter int unsigned RESULT_WIDTH     = 16,
    parameter int unsigned RAM_ADDR_WIDTH   = 8,
    parameter int unsigned MATCH_CELL_CNT   = 4,
    parameter int unsigned CELL_IDX_WIDTH   = (MATCH_CELL_CNT > 1) ? $clog2(MATCH_CELL_CNT) : 1,
    parameter int unsigned BYPASS_WIDTH     = 8,
    parameter int unsigned PRIORITY_HIGHEST = 1,
    localparam int unsigned ENTRY_W         = entry_width(KEY_WIDTH, RESULT_WIDTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [RAM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [CELL_IDX_WIDTH-1:0] wr_cell_i,
    input  logic [ENTRY_W-1:0]        wr_entry_i,
    input  logic                      wr_en_i,
    input  logic [RAM_ADDR_WIDTH-1:0] in_addr_i,
    input  logic [KEY_WIDTH-1:0]      in_key_i,
    input  logic [BYPASS_WIDTH-1:0]   in_bypass_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_match_o,
    output logic                      out_multi_o,
    output logic [CELL_IDX_WIDTH-1:0] out_cell_o,
    output logic [RESULT_WIDTH-1:0]   out_result_o,
    output logic [BYPASS_WIDTH-1:0]   out_bypass_o,
    input  logic                      stat_clr_i,
    output logic [STAT_WIDTH-1:0]     stat_lookups_o,
    output logic [STAT_WIDTH-1:0]     stat_hits_o
);

    logic                      adv;
    logic                      v0;
    logic                      v1;
    logic [KEY_WIDTH-1:0]      key0;
    logic [BYPASS_WIDTH-1:0]   byp0;
    logic [BYPASS_WIDTH-1:0]   byp1;
    logic [MATCH_CELL_CNT-1:0] hit1;
    logic [RESULT_WIDTH-1:0]   res1 [MATCH_CELL_CNT];
    penc_t                     enc;
    logic [RESULT_WIDTH-1:0]   sel_result;
    logic                      sel_hit;

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    for (genvar i = 0; i < MATCH_CELL_CNT; i++) begin : g_cell
        qtree_match_cell #(
            .KEY_WIDTH     (KEY_WIDTH),
            .RESULT_WIDTH  (RESULT_WIDTH),
            .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH)
        ) u_cell (
            .clk_i     (clk_i),
            .adv_i     (adv),
            .wr_en_i   (wr_en_i && (wr_cell_i == CELL_IDX_WIDTH'(i))),
            .wr_addr_i (wr_addr_i),
            .wr_entry_i(wr_entry_i),
            .rd_addr_i (in_addr_i),
            .key_i     (key0),
            .hit_o     (hit1[i]),
            .result_o  (res1[i])
        );
    end

    // Stage valid bits; reset drops anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (adv) begin
            v0 <= in_valid_i;
            v1 <= v0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            key0 <= in_key_i;
            byp0 <= in_bypass_i;
            byp1 <= byp0;
        end
    end

    always_comb begin
        enc        = prio_encode(PENC_MAX'(hit1), PRIORITY_HIGHEST != 0);
        sel_result = '0;
        for (int i = 0; i < MATCH_CELL_CNT; i++) begin
            if (enc.idx == PENC_IDX_W'(i)) sel_result = res1[i];
        end
        sel_hit = v1 && enc.any;
    end

    // S2 output registers; cell and result read as 0 on a miss.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            out_match_o  <= 1'b0;
            out_multi_o  <= 1'b0;
            out_cell_o   <= '0;
            out_result_o <= '0;
            out_bypass_o <= '0;
        end else if (adv) begin
            out_valid_o  <= v1;
            out_match_o  <= sel_hit;
            out_multi_o  <= v1 && enc.multi;
            out_cell_o   <= sel_hit ? CELL_IDX_WIDTH'(enc.idx) : '0;
            out_result_o <= sel_hit ? sel_result : '0;
            out_bypass_o <= byp1;
        end
    end

`ifdef QTREE_MATCH_STATS_EN
    logic done;
    assign done = out_valid_o && out_ready_i;

    // Saturating counters; clear wins over a same-cycle completion.
    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            stat_lookups_o <= '0;
            stat_hits_o    <= '0;
        end else if (done) begin
            if (stat_lookups_o != '1) stat_lookups_o <= stat_lookups_o + STAT_WIDTH'(1);
            if (out_match_o && (stat_hits_o != '1)) stat_hits_o <= stat_hits_o + STAT_WIDTH'(1);
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr_i;
    assign stat_lookups_o  = '0;
    assign stat_hits_o     = '0;
`endif

endmodule

// File: tb/tb_qtree_range_match.sv
// Directed bench for qtree_range_match: one instance per priority mode sharing all inputs.
module tb_qtree_range_match;

`ifdef QTREE_MATCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, wr_en_i, in_valid_i, out_ready_i, stat_clr_i;
    logic [7:0]  wr_addr_i, in_addr_i, in_bypass_i;
    logic [1:0]  wr_cell_i;
    logic [40:0] wr_entry_i;
    logic [15:0] in_key_i;

    logic        rdy_hi, val_hi, match_hi, multi_hi;
    logic [1:0]  cell_hi;
    logic [7:0]  res_hi, byp_hi;
    logic [31:0] lk_hi, hit_hi;
    logic        rdy_lo, val_lo, match_lo, multi_lo;
    logic [1:0]  cell_lo;
    logic [7:0]  res_lo, byp_lo;
    logic [31:0] lk_lo, hit_lo;

    int errors = 0;
    int checks = 0;
    int lat;
    int sent, rcv;
    bit seen;

    logic [15:0] bp_key  [8] = '{16'd50, 16'd150, 16'd250, 16'd50, 16'd150, 16'd250, 16'd50, 16'd50};
    logic [7:0]  bp_res  [8] = '{8'h60, 8'h61, 8'h62, 8'h60, 8'h61, 8'h62, 8'h99, 8'h99};
    logic [1:0]  bp_cell [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};

    always #5 clk = ~clk;

    qtree_range_match #(
        .KEY_WIDTH(16), .RESULT_WIDTH(8), .RAM_ADDR_WIDTH(8), .MATCH_CELL_CNT(4),
        .CELL_IDX_WIDTH(2), .BYPASS_WIDTH(8), .PRIORITY_HIGHEST(1)
    ) dut_hi (
        .clk_i(clk), .rst_i(rst_i), .wr_addr_i(wr_addr_i), .wr_cell_i(wr_cell_i),
        .wr_entry_i(wr_entry_i), .wr_en_i(wr_en_i), .in_addr_i(in_addr_i),
        .in_key_i(in_key_i), .in_bypass_i(in_bypass_i), .in_valid_i(in_valid_i),
        .in_ready_o(rdy_hi), .out_valid_o(val_hi), .out_ready_i(out_ready_i),
        .out_match_o(match_hi), .out_multi_o(multi_hi), .out_cell_o(cell_hi),
        .out_result_o(res_hi), .out_bypass_o(byp_hi), .stat_clr_i(stat_clr_i),
        .stat_lookups_o(lk_hi), .stat_hits_o(hit_hi)
    );

    qtree_range_match #(
        .KEY_WIDTH(16), .RESULT_WIDTH(8), .RAM_ADDR_WIDTH(8), .MATCH_CELL_CNT(4),
        .CELL_IDX_WIDTH(2), .BYPASS_WIDTH(8), .PRIORITY_HIGHEST(0)
    ) dut_lo (
        .clk_i(clk), .rst_i(rst_i), .wr_addr_i(wr_addr_i), .wr_cell_i(wr_cell_i),
        .wr_entry_i(wr_entry_i), .wr_en_i(wr_en_i), .in_addr_i(in_addr_i),
        .in_key_i(in_key_i), .in_bypass_i(in_bypass_i), .in_valid_i(in_valid_i),
        .in_ready_o(rdy_lo), .out_valid_o(val_lo), .out_ready_i(out_ready_i),
        .out_match_o(match_lo), .out_multi_o(multi_lo), .out_cell_o(cell_lo),
        .out_result_o(res_lo), .out_bypass_o(byp_lo), .stat_clr_i(stat_clr_i),
        .stat_lookups_o(lk_lo), .stat_hits_o(hit_lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cell(input logic [7:0] a, input logic [1:0] c, input logic v,
                              input logic [15:0] l, input logic [15:0] r, input logic [7:0] res);
        @(negedge clk);
        wr_addr_i  = a;
        wr_cell_i  = c;
        wr_entry_i = {v, l, r, res};
        wr_en_i    = 1'b1;
        @(negedge clk);
        wr_en_i    = 1'b0;
    endtask

    // Presents one lookup and returns at the first negedge where out_valid is seen (bounded).
    task automatic lookup(input logic [7:0] a, input logic [15:0] k, input logic [7:0] b, input bit with_wr);
        @(negedge clk);
        in_addr_i   = a;
        in_key_i    = k;
        in_bypass_i = b;
        in_valid_i  = 1'b1;
        wr_en_i     = with_wr;
        @(negedge clk);
        in_valid_i  = 1'b0;
        wr_en_i     = 1'b0;
        lat         = 1;
        while (!val_hi && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        rst_i = 1'b1; wr_en_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; stat_clr_i = 1'b0;
        wr_addr_i = '0; wr_cell_i = '0; wr_entry_i = '0; in_addr_i = '0; in_key_i = '0; in_bypass_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(val_hi), 32'd0);
        chk("rst_match", 32'(match_hi), 32'd0);
        chk("rst_cell", 32'(cell_hi), 32'd0);
        chk("rst_result", 32'(res_hi), 32'd0);
        chk("rst_bypass", 32'(byp_hi), 32'd0);
        chk("rst_stats", lk_hi, 32'd0);
        rst_i = 1'b0;

        for (int a = 2; a <= 6; a++)
            for (int c = 0; c < 4; c++) write_cell(8'(a), 2'(c), 1'b0, 16'd0, 16'd0, 8'h00);
        write_cell(8'd3, 2'd1, 1'b1, 16'd10, 16'd20, 8'hAB);
        write_cell(8'd4, 2'd0, 1'b1, 16'd0, 16'd10, 8'h10);
        write_cell(8'd4, 2'd2, 1'b1, 16'd5, 16'd5, 8'h30);
        write_cell(8'd5, 2'd0, 1'b1, 16'd30, 16'd5, 8'h77);
        write_cell(8'd2, 2'd0, 1'b1, 16'd0, 16'd100, 8'h11);
        write_cell(8'd6, 2'd0, 1'b1, 16'd0, 16'd99, 8'h60);
        write_cell(8'd6, 2'd1, 1'b1, 16'd100, 16'd199, 8'h61);
        write_cell(8'd6, 2'd2, 1'b1, 16'd200, 16'd299, 8'h62);

        lookup(8'd3, 16'd15, 8'h5A, 1'b0);
        chk("single_lat", 32'(lat), 32'd3);
        chk("single_match", 32'(match_hi), 32'd1);
        chk("single_cell", 32'(cell_hi), 32'd1);
        chk("single_result", 32'(res_hi), 32'hAB);
        chk("single_multi", 32'(multi_hi), 32'd0);
        chk("single_bypass", 32'(byp_hi), 32'h5A);

        lookup(8'd3, 16'd9, 8'h01, 1'b0);
        chk("bound_9", 32'(match_hi), 32'd0);
        lookup(8'd3, 16'd10, 8'h02, 1'b0);
        chk("bound_10", 32'(match_hi), 32'd1);
        lookup(8'd3, 16'd20, 8'h03, 1'b0);
        chk("bound_20", 32'(match_hi), 32'd1);
        lookup(8'd3, 16'd21, 8'h04, 1'b0);
        chk("bound_21", 32'(match_hi), 32'd0);
        chk("bound_21_result", 32'(res_hi), 32'd0);

        lookup(8'd4, 16'd5, 8'h05, 1'b0);
        chk("prio_hi_cell", 32'(cell_hi), 32'd2);
        chk("prio_hi_multi", 32'(multi_hi), 32'd1);
        chk("prio_hi_result", 32'(res_hi), 32'h30);
        chk("prio_lo_valid", 32'(val_lo), 32'd1);
        chk("prio_lo_cell", 32'(cell_lo), 32'd0);
        chk("prio_lo_multi", 32'(multi_lo), 32'd1);
        chk("prio_lo_result", 32'(res_lo), 32'h10);
        @(negedge clk);
        chk("stat_lookups", lk_hi, STATS_ON ? 32'd6 : 32'd0);
        chk("stat_hits", hit_hi, STATS_ON ? 32'd4 : 32'd0);
        chk("stat_lookups_lo", lk_lo, STATS_ON ? 32'd6 : 32'd0);
        stat_clr_i = 1'b1;
        @(negedge clk);
        stat_clr_i = 1'b0;
        chk("stat_clr", lk_hi, 32'd0);

        lookup(8'd5, 16'd10, 8'h06, 1'b0);
        chk("inv_match", 32'(match_hi), 32'd0);
        chk("inv_cell", 32'(cell_hi), 32'd0);
        chk("inv_result", 32'(res_hi), 32'd0);

        wr_addr_i = 8'd2; wr_cell_i = 2'd0; wr_entry_i = {1'b1, 16'd0, 16'd100, 8'h22};
        lookup(8'd2, 16'd50, 8'hC1, 1'b1);
        chk("coll_old", 32'(res_hi), 32'h11);
        lookup(8'd2, 16'd50, 8'hC2, 1'b0);
        chk("coll_new", 32'(res_hi), 32'h22);

        // Streamed lookups on row 6 with a 5-cycle downstream stall and a write during it.
        wr_addr_i = 8'd6; wr_cell_i = 2'd0; wr_entry_i = {1'b1, 16'd0, 16'd99, 8'h99};
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready_i = !(c >= 5 && c <= 9);
            wr_en_i     = (c == 6);
            #1;
            if (val_hi && out_ready_i) begin
                if (rcv < 8) begin
                    chk("bp_result", 32'(res_hi), 32'(bp_res[rcv]));
                    chk("bp_cell", 32'(cell_hi), 32'(bp_cell[rcv]));
                    chk("bp_bypass", 32'(byp_hi), 32'(rcv));
                end
                rcv++;
            end
            if (c >= 5 && c <= 9) begin
                chk("stall_ready", 32'(rdy_hi), 32'd0);
                chk("stall_valid", 32'(val_hi), 32'd1);
                chk("stall_result", 32'(res_hi), 32'h62);
                chk("stall_bypass", 32'(byp_hi), 32'd2);
            end
            in_valid_i  = (sent < 8);
            in_addr_i   = 8'd6;
            in_key_i    = (sent < 8) ? bp_key[sent] : 16'd0;
            in_bypass_i = 8'(sent);
            #1;
            if (in_valid_i && rdy_hi) sent++;
        end
        in_valid_i  = 1'b0;
        wr_en_i     = 1'b0;
        out_ready_i = 1'b1;
        chk("bp_count", 32'(rcv), 32'd8);

        @(negedge clk);
        in_addr_i = 8'd3; in_key_i = 16'd15; in_bypass_i = 8'hE1; in_valid_i = 1'b1;
        @(negedge clk);
        in_bypass_i = 8'hE2;
        @(negedge clk);
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (val_hi) seen = 1'b1;
        end
        chk("rst_drop", 32'(seen), 32'd0);
        chk("rst_lookups", lk_hi, 32'd0);
        chk("rst_hits", hit_hi, 32'd0);
        chk("rst_out_match", 32'(match_hi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
